cic_decim_ctrl: RTL and testbench
=================================

Name: cic_decim_ctrl

Overview:
- Sequencer for the CIC decimation datapath: turns the sample-rate strobe from divClock into integrator-advance, comb-advance and clear strobes.
- Counts the decimation ratio R and discards the first N_STAGES decimated outputs while the combs fill (warm-up).
- Presents each decimated result with a valid/ready handshake to the consumer (PWM/display path).
- Supports run-time ratio change, applied only at a decimation boundary, followed by a datapath clear.

Parameters:
- R_MAX, 64: largest supported decimation ratio.
- R_DEFAULT, 8: ratio after reset; must satisfy 1 ≤ R_DEFAULT ≤ R_MAX.
- N_STAGES, 3: CIC order; number of decimated outputs discarded after each clear.
- RW, $clog2(R_MAX+1): localparam; width of the ratio and phase fields.

Ports:
- clock, input, 1: system clock.
- nreset, input, 1: asynchronous active-low reset.
- enable, input, 1: run request; level-sensitive.
- sample_tick, input, 1: one-cycle input-sample strobe.
- ratio, input, RW: requested decimation ratio.
- ratio_load, input, 1: one-cycle request to adopt `ratio`.
- out_ready, input, 1: consumer accepts the current result.
- integ_en, output, 1: integrator-chain advance strobe.
- comb_en, output, 1: comb-chain advance strobe.
- stage_clr, output, 1: synchronous clear of all datapath registers.
- out_valid, output, 1: decimated result available.
- overrun, output, 1: sticky flag; a result was lost.
- phase, output, RW: current position within the decimation period, 0..R-1.
- state_o, output, 2: current FSM state, for debug and display.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `nreset` is asynchronous and active-low.
- Reset values:
  - state = IDLE; ratio_q = R_DEFAULT; pending flag = 0.
  - phase = 0; warm_cnt = 0.
  - integ_en, comb_en, stage_clr, out_valid and overrun all 0.
- FSM states (shared enum): IDLE = 0, CLEAR = 1, WARMUP = 2, RUN = 3.
  - IDLE: all strobes 0; ticks ignored. enable = 1 → CLEAR.
  - CLEAR: lasts exactly 1 cycle with stage_clr = 1. On entry:
    - phase ← 0, warm_cnt ← 0, overrun ← 0, out_valid ← 0.
    - If a ratio is pending: ratio_q ← pending value, pending flag ← 0.
    - Next state → WARMUP.
  - WARMUP: normal sequencing, but results are never marked valid.
    - Each comb_en increments warm_cnt.
    - The cycle comb_en fires with warm_cnt = N_STAGES-1 → RUN.
  - RUN: normal sequencing, and results are marked valid.
  - enable = 0 in any state → IDLE on the next edge. In-flight strobes are dropped and out_valid is cleared; overrun is held.
- Sequencing (WARMUP and RUN):
  - Latency: sample_tick at cycle t → integ_en = 1 at t+1.
  - Phase counting on each tick: phase ← phase+1. If phase = ratio_q-1 the tick is a wrap: phase ← 0 and the tick is marked boundary.
  - Boundary tick at t → comb_en = 1 at t+2.
  - In RUN, out_valid is set at t+3.
  - ratio_q = 1: every tick is a boundary.
  - Back-to-back ticks are legal; each tick produces its own pulses. Strobes are always single-cycle.
- Handshake:
  - out_valid stays high until a cycle with out_valid & out_ready; it then clears at the next edge.
  - If a set event coincides with a handshake, out_valid stays 1.
  - If a set event occurs while out_valid & !out_ready: overrun ← 1 (sticky) and out_valid stays 1.
  - overrun clears only on reset or CLEAR entry.
- Ratio load:
  - Values outside 1..R_MAX are ignored.
  - In IDLE: ratio_q updates immediately.
  - In WARMUP/RUN: the value goes to pending. At the next boundary tick, comb_en for that period is still issued, then the FSM goes to CLEAR on the cycle after comb_en.
  - A second load before the boundary overwrites the pending value.
  - A load during CLEAR goes to pending, and applies at the next boundary.
- sample_tick during CLEAR or IDLE is dropped; no pulse is generated and phase does not change.
- phase and state_o are registered and valid every cycle.

Decomposition:
- Package cic_ctrl_pkg:
  - typedef enum logic [1:0] cic_state_t (IDLE, CLEAR, WARMUP, RUN).
  - Default parameter constants.
- One sub-module, cic_phase_counter: tick-driven modulo-R counter.
  - Inputs: clock, nreset, clr, tick, ratio_q.
  - Outputs: phase, boundary.
- The top level holds the FSM, the pulse pipeline, the handshake and the pending-ratio logic.

Test Plan:
- Reset/idle: assert nreset low mid-run, and tick with enable = 0 → all outputs 0, phase = 0, state_o = 0, no strobes.
- Warm-up, R = 4, N = 3, out_ready = 1, tick every 5 cycles:
  - One stage_clr pulse.
  - Ticks 1–12 → 12 integ_en and 3 comb_en, out_valid never set.
  - Tick 16 → comb_en at +2, out_valid at +3, then one result every 4 ticks.
- Ratio change, load ratio = 2 at phase 1 of a R = 4 period:
  - The boundary comb_en is still issued, stage_clr follows on the next cycle.
  - Afterwards a boundary occurs every 2 ticks, with 6 warm-up ticks.
- Back-pressure, out_ready = 0 across two boundaries → out_valid held, overrun = 1 after the second boundary; CLEAR resets overrun.
- Edge ratios:
  - R = 1, back-to-back ticks → integ_en and comb_en asserted every cycle, offset by 1.
  - ratio = 0 or R_MAX+1 loaded → ratio_q unchanged.
- Coincident handshake and set event → out_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/cic_decim_ctrl_pkg.sv
// Shared definitions for the CIC decimation sequencer.
//   cic_state_t     : sequencer FSM encoding (also exported on state_o)
//   CIC_*           : default parameter values for the controller
//   ratio_in_range  : legality check for a requested decimation ratio
package cic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } cic_state_t;

  localparam int CIC_R_MAX     = 64;
  localparam int CIC_R_DEFAULT = 8;
  localparam int CIC_N_STAGES  = 3;

  function automatic logic ratio_in_range(input int r, input int r_max);
    return (r >= 1) && (r <= r_max);
  endfunction

endpackage

// File: rtl/cic_phase_counter.sv
// Tick-driven modulo-R phase counter for the CIC sequencer.
//   clock, nreset : clock and asynchronous active-low reset
//   clr           : synchronous clear of phase and boundary
//   tick          : advance strobe (already gated by the caller)
//   ratio_q       : active decimation ratio R (1..R_MAX)
//   phase         : position within the decimation period, 0..R-1
//   boundary      : registered one-cycle pulse, the cycle after a wrapping tick
module cic_phase_counter #(
  parameter int RW = 7
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          clr,
  input  logic          tick,
  input  logic [RW-1:0] ratio_q,
  output logic [RW-1:0] phase,
  output logic          boundary
);

  logic [RW-1:0] last;
  logic          wrap;

  assign last = ratio_q - RW'(1);
  // >= rather than == so a phase left beyond the period still wraps.
  assign wrap = (phase >= last);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      phase    <= '0;
      boundary <= 1'b0;
    end else if (clr) begin
      phase    <= '0;
      boundary <= 1'b0;
    end else begin
      boundary <= tick && wrap;
      if (tick) begin
        phase <= wrap ? '0 : phase + RW'(1);
      end
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencer for the CIC decimation datapath.
// Turns sample_tick into integrator/comb advance strobes, discards the first
// N_STAGES decimated outputs after every clear, and offers each result to the
// consumer with a valid/ready handshake. Ratio changes are deferred to a
// decimation boundary and followed by a datapath clear.
//   clock, nreset : clock and asynchronous active-low reset
//   enable        : run request (level)
//   sample_tick   : one-cycle input sample strobe
//   ratio         : requested decimation ratio
//   ratio_load    : one-cycle request to adopt ratio
//   out_ready     : consumer accepts the current result
//   integ_en      : integrator advance, tick + 1
//   comb_en       : comb advance, boundary tick + 2
//   stage_clr     : datapath clear, high for the single CLEAR cycle
//   out_valid     : decimated result available (RUN only), boundary tick + 3
//   overrun       : sticky, a result was overwritten before acceptance
//   phase         : position within the decimation period
//   state_o       : FSM state
module cic_decim_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter  int R_MAX     = CIC_R_MAX,
  parameter  int R_DEFAULT = CIC_R_DEFAULT,
  parameter  int N_STAGES  = CIC_N_STAGES,
  localparam int RW        = $clog2(R_MAX + 1)
) (
  input  logic          clock,
  input  logic          nreset,
  input  logic          enable,
  input  logic          sample_tick,
  input  logic [RW-1:0] ratio,
  input  logic          ratio_load,
  input  logic          out_ready,
  output logic          integ_en,
  output logic          comb_en,
  output logic          stage_clr,
  output logic          out_valid,
  output logic          overrun,
  output logic [RW-1:0] phase,
  output logic [1:0]    state_o
);

  localparam int WW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  cic_state_t    state;
  cic_state_t    state_nx;
  logic [RW-1:0] ratio_q;
  logic [RW-1:0] pend_val;
  logic          pend;
  logic [WW-1:0] warm_cnt;
  logic          boundary;

  logic active;
  logic flush;
  logic clr_entry;
  logic load_ok;
  logic set_ev;
  logic cnt_tick;
  logic warm_last;

  assign active    = (state == WARMUP) || (state == RUN);
  // Anything leaving the sequencing states drops the in-flight pipeline.
  assign flush     = (state_nx == IDLE) || (state_nx == CLEAR);
  assign clr_entry = (state_nx == CLEAR) && (state != CLEAR);
  assign load_ok   = ratio_load && ratio_in_range(int'(ratio), R_MAX);
  assign set_ev    = comb_en && (state == RUN);
  assign cnt_tick  = sample_tick && active;
  assign warm_last = (warm_cnt == WW'(N_STAGES - 1));

  assign stage_clr = (state == CLEAR);
  assign state_o   = state;

  cic_phase_counter #(
    .RW(RW)
  ) u_phase (
    .clock   (clock),
    .nreset  (nreset),
    .clr     (flush),
    .tick    (cnt_tick),
    .ratio_q (ratio_q),
    .phase   (phase),
    .boundary(boundary)
  );

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a pending ratio turns the boundary comb_en into a clear.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable) state_nx = CLEAR;
      CLEAR:   state_nx = WARMUP;
      WARMUP: begin
        if (comb_en) begin
          if (pend)           state_nx = CLEAR;
          else if (warm_last) state_nx = RUN;
        end
      end
      RUN:     if (comb_en && pend) state_nx = CLEAR;
      default: state_nx = IDLE;
    endcase
    if (!enable) state_nx = IDLE;
  end

  // Strobe pipeline: tick -> integ_en (+1); boundary (+1) -> comb_en (+2)
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      integ_en <= 1'b0;
      comb_en  <= 1'b0;
    end else begin
      integ_en <= !flush && cnt_tick;
      comb_en  <= !flush && boundary;
    end
  end

  // Warm-up counter: comb outputs seen since the last clear
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      warm_cnt <= '0;
    end else if (clr_entry) begin
      warm_cnt <= '0;
    end else if (comb_en && (state == WARMUP)) begin
      warm_cnt <= warm_cnt + WW'(1);
    end
  end

  // Result handshake and sticky overrun
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      if (clr_entry) overrun <= 1'b0;
    end else if (set_ev) begin
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Ratio register and pending request. A new load in the same cycle as the
  // clear entry is written after the pending value is consumed, so it wins.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      ratio_q  <= RW'(R_DEFAULT);
      pend_val <= RW'(R_DEFAULT);
      pend     <= 1'b0;
    end else begin
      if (clr_entry && pend) begin
        ratio_q <= pend_val;
        pend    <= 1'b0;
      end
      if (load_ok) begin
        if (state == IDLE) begin
          ratio_q <= ratio;
          pend    <= 1'b0;
        end else begin
          pend_val <= ratio;
          pend     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
module tb_cic_decim_ctrl;
  import cic_ctrl_pkg::*;

  localparam int RW = 7;

  logic          clock;
  logic          nreset;
  logic          enable;
  logic          sample_tick;
  logic [RW-1:0] ratio;
  logic          ratio_load;
  logic          out_ready;
  logic          integ_en;
  logic          comb_en;
  logic          stage_clr;
  logic          out_valid;
  logic          overrun;
  logic [RW-1:0] phase;
  logic [1:0]    state_o;

  cic_decim_ctrl #(
    .R_MAX    (64),
    .R_DEFAULT(8),
    .N_STAGES (3)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .enable     (enable),
    .sample_tick(sample_tick),
    .ratio      (ratio),
    .ratio_load (ratio_load),
    .out_ready  (out_ready),
    .integ_en   (integ_en),
    .comb_en    (comb_en),
    .stage_clr  (stage_clr),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .phase      (phase),
    .state_o    (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Strobe/valid activity counters, sampled mid-cycle
  int n_integ = 0;
  int n_comb  = 0;
  int n_clr   = 0;
  int n_valid = 0;

  always @(negedge clock) begin
    if (nreset) begin
      n_integ <= n_integ + int'(integ_en);
      n_comb  <= n_comb + int'(comb_en);
      n_clr   <= n_clr + int'(stage_clr);
      n_valid <= n_valid + int'(out_valid);
    end
  end

  typedef struct {
    logic          en;
    logic          tick;
    logic [RW-1:0] rat;
    logic          load;
    logic          rdy;
    logic          integ;
    logic          comb;
    logic          clr;
    logic          valid;
    logic          ovr;
    logic [RW-1:0] ph;
    logic [1:0]    st;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic en, input logic tick, input int rat,
                              input logic load, input logic rdy,
                              input logic integ, input logic comb, input logic clr,
                              input logic valid, input logic ovr, input int ph,
                              input int st);
    vec_t v;
    v.en = en; v.tick = tick; v.rat = RW'(rat); v.load = load; v.rdy = rdy;
    v.integ = integ; v.comb = comb; v.clr = clr; v.valid = valid; v.ovr = ovr;
    v.ph = RW'(ph); v.st = 2'(st);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_gap(input int gap);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    repeat (gap - 1) cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_gap(5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int s_integ, s_comb, s_clr, s_valid;

  task automatic snap();
    s_integ = n_integ; s_comb = n_comb; s_clr = n_clr; s_valid = n_valid;
  endtask

  initial begin
    //            en tk rat ld rdy  int cmb clr val ovr ph st
    tbl[0]  = mk(0, 1,  0, 0, 1,   0,  0,  0,  0,  0,  0, 0); // tick ignored in IDLE
    tbl[1]  = mk(0, 0,  1, 1, 1,   0,  0,  0,  0,  0,  0, 0); // R=1 taken in IDLE
    tbl[2]  = mk(0, 0,  0, 1, 1,   0,  0,  0,  0,  0,  0, 0); // 0 ignored
    tbl[3]  = mk(0, 0, 65, 1, 1,   0,  0,  0,  0,  0,  0, 0); // R_MAX+1 ignored
    tbl[4]  = mk(1, 0,  0, 0, 1,   0,  0,  1,  0,  0,  0, 1);
    tbl[5]  = mk(1, 1,  0, 0, 1,   0,  0,  0,  0,  0,  0, 2); // tick in CLEAR dropped
    tbl[6]  = mk(1, 1,  0, 0, 1,   1,  0,  0,  0,  0,  0, 2);
    tbl[7]  = mk(1, 1,  0, 0, 1,   1,  1,  0,  0,  0,  0, 2);
    tbl[8]  = mk(1, 1,  0, 0, 1,   1,  1,  0,  0,  0,  0, 2);
    tbl[9]  = mk(1, 1,  0, 0, 1,   1,  1,  0,  0,  0,  0, 2);
    tbl[10] = mk(1, 1,  0, 0, 1,   1,  1,  0,  0,  0,  0, 3);
    tbl[11] = mk(1, 1,  0, 0, 1,   1,  1,  0,  1,  0,  0, 3);
    tbl[12] = mk(1, 0,  0, 0, 1,   0,  1,  0,  1,  0,  0, 3); // set + handshake
    tbl[13] = mk(1, 0,  0, 0, 0,   0,  0,  0,  1,  1,  0, 3); // set while stalled
    tbl[14] = mk(1, 0,  0, 0, 0,   0,  0,  0,  1,  1,  0, 3);
    tbl[15] = mk(1, 0,  0, 0, 1,   0,  0,  0,  0,  1,  0, 3);
    tbl[16] = mk(0, 0,  0, 0, 1,   0,  0,  0,  0,  1,  0, 0); // overrun held in IDLE
    tbl[17] = mk(0, 0,  0, 0, 1,   0,  0,  0,  0,  1,  0, 0);
    tbl[18] = mk(1, 0,  0, 0, 1,   0,  0,  1,  0,  0,  0, 1); // CLEAR drops overrun
    tbl[19] = mk(1, 0,  0, 0, 1,   0,  0,  0,  0,  0,  0, 2);
    tbl[20] = mk(1, 1,  0, 0, 1,   1,  0,  0,  0,  0,  0, 2);
    tbl[21] = mk(0, 0,  0, 0, 1,   0,  0,  0,  0,  0,  0, 0); // in-flight comb dropped

    nreset = 1'b0; enable = 1'b0; sample_tick = 1'b0; ratio = '0;
    ratio_load = 1'b0; out_ready = 1'b1;
    repeat (2) cyc();
    chk("reset state", int'(state_o), 0);
    chk("reset phase", int'(phase), 0);
    chk("reset strobes", int'({integ_en, comb_en, stage_clr, out_valid, overrun}), 0);
    nreset = 1'b1;
    cyc();

    for (int i = 0; i < NV; i++) begin
      enable = tbl[i].en; sample_tick = tbl[i].tick; ratio = tbl[i].rat;
      ratio_load = tbl[i].load; out_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("row%0d integ_en", i), int'(integ_en), int'(tbl[i].integ));
      chk($sformatf("row%0d comb_en", i), int'(comb_en), int'(tbl[i].comb));
      chk($sformatf("row%0d stage_clr", i), int'(stage_clr), int'(tbl[i].clr));
      chk($sformatf("row%0d out_valid", i), int'(out_valid), int'(tbl[i].valid));
      chk($sformatf("row%0d overrun", i), int'(overrun), int'(tbl[i].ovr));
      chk($sformatf("row%0d phase", i), int'(phase), int'(tbl[i].ph));
      chk($sformatf("row%0d state", i), int'(state_o), int'(tbl[i].st));
    end
    sample_tick = 1'b0; ratio_load = 1'b0; out_ready = 1'b1;

    // Warm-up with R=4, one tick every 5 cycles
    ratio = RW'(4); ratio_load = 1'b1; cyc(); ratio_load = 1'b0;
    snap();
    enable = 1'b1;
    cyc(); cyc();
    chk("A state warmup", int'(state_o), 2);
    ticks(12);
    chk("A warm integ count", n_integ - s_integ, 12);
    chk("A warm comb count", n_comb - s_comb, 3);
    chk("A warm clr count", n_clr - s_clr, 1);
    chk("A warm valid count", n_valid - s_valid, 0);
    chk("A state run", int'(state_o), 3);
    chk("A phase after 12", int'(phase), 0);
    ticks(3);
    chk("A phase after 15", int'(phase), 3);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("A t16 integ t+1", int'(integ_en), 1);
    chk("A t16 comb t+1", int'(comb_en), 0);
    cyc();
    chk("A t16 comb t+2", int'(comb_en), 1);
    chk("A t16 valid t+2", int'(out_valid), 0);
    cyc();
    chk("A t16 valid t+3", int'(out_valid), 1);
    chk("A t16 comb t+3", int'(comb_en), 0);
    cyc();
    chk("A t16 valid accepted", int'(out_valid), 0);
    cyc();
    snap();
    ticks(4);
    chk("A period integ", n_integ - s_integ, 4);
    chk("A period comb", n_comb - s_comb, 1);
    chk("A period valid", n_valid - s_valid, 1);

    // Ratio change to 2 (second load overwrites the first) mid-period
    ticks(1);
    chk("B phase 1", int'(phase), 1);
    ratio = RW'(3); ratio_load = 1'b1; cyc();
    ratio = RW'(2); cyc();
    ratio_load = 1'b0;
    snap();
    ticks(2);
    chk("B phase 3", int'(phase), 3);
    chk("B still run", int'(state_o), 3);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("B bnd integ", int'(integ_en), 1);
    cyc();
    chk("B bnd comb", int'(comb_en), 1);
    chk("B bnd state", int'(state_o), 3);
    cyc();
    chk("B clear state", int'(state_o), 1);
    chk("B clear strobe", int'(stage_clr), 1);
    chk("B clear valid", int'(out_valid), 0);
    chk("B clear phase", int'(phase), 0);
    cyc();
    chk("B after clear", int'(state_o), 2);
    chk("B clr count", n_clr - s_clr, 1);
    snap();
    ticks(6);
    chk("B warm comb", n_comb - s_comb, 3);
    chk("B warm valid", n_valid - s_valid, 0);
    chk("B run", int'(state_o), 3);
    snap();
    ticks(1);
    chk("B R2 phase", int'(phase), 1);
    ticks(1);
    chk("B R2 comb", n_comb - s_comb, 1);
    chk("B R2 valid", n_valid - s_valid, 1);

    // Back-pressure across two boundaries
    out_ready = 1'b0;
    ticks(2);
    chk("C valid held 1", int'(out_valid), 1);
    chk("C no overrun yet", int'(overrun), 0);
    ticks(2);
    chk("C valid held 2", int'(out_valid), 1);
    chk("C overrun", int'(overrun), 1);
    out_ready = 1'b1; cyc();
    chk("C accepted", int'(out_valid), 0);
    chk("C overrun sticky", int'(overrun), 1);
    enable = 1'b0; cyc();
    chk("C idle overrun", int'(overrun), 1);
    enable = 1'b1; cyc();
    chk("C clear state", int'(state_o), 1);
    chk("C clear overrun", int'(overrun), 0);
    cyc();

    // Asynchronous reset mid-run, then default ratio
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("D integ before rst", int'(integ_en), 1);
    nreset = 1'b0;
    #1;
    chk("D async state", int'(state_o), 0);
    chk("D async outs", int'({integ_en, comb_en, stage_clr, out_valid, overrun}), 0);
    chk("D async phase", int'(phase), 0);
    enable = 1'b0;
    cyc();
    nreset = 1'b1;
    snap();
    sample_tick = 1'b1; repeat (3) cyc(); sample_tick = 1'b0;
    cyc();
    chk("D idle integ", n_integ - s_integ, 0);
    chk("D idle state", int'(state_o), 0);
    chk("D idle phase", int'(phase), 0);
    enable = 1'b1; cyc(); cyc();
    snap();
    ticks(7);
    chk("D default phase 7", int'(phase), 7);
    chk("D no comb yet", n_comb - s_comb, 0);
    ticks(1);
    chk("D default wrap", int'(phase), 0);
    chk("D default comb", n_comb - s_comb, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
